// File: rtl/video_sprite_display.sv
// rtl/video_sprite_display.sv - bouncing 1-bpp ROM sprite renderer with border, power-of-two scaling
// and ROM latency compensation; pixel_data trails the sampled coordinates by ROM_LAT+1 clocks.
module video_sprite_display #(
  parameter int          H_DISP       = 800,
  parameter int          V_DISP       = 600,
  parameter int          IMG_W        = 256,
  parameter int          IMG_H        = 256,
  parameter int          ADDR_W       = 16,
  parameter int          SCALE_LOG2   = 0,
  parameter int          BORDER_W     = 2,
  parameter int          ROM_LAT      = 1,
  parameter int          STEP         = 1,
  parameter logic [23:0] FG_COLOR     = 24'hC030A0,
  parameter logic [23:0] BG_COLOR     = 24'h000000,
  parameter logic [23:0] BORDER_COLOR = 24'hFF0000
) (
  input  logic              pixel_clk,
  input  logic              sys_rst_n,
  input  logic [10:0]       pixel_xpos,
  input  logic [10:0]       pixel_ypos,
  input  logic              move_en,
  input  logic              invert,
  input  logic              rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [23:0]       pixel_data,
  output logic [10:0]       img_x,
  output logic [10:0]       img_y,
  output logic              bounce
);

  localparam int SW    = IMG_W << SCALE_LOG2;
  localparam int SH    = IMG_H << SCALE_LOG2;
  localparam int MAX_X = H_DISP - SW;
  localparam int MAX_Y = V_DISP - SH;

  typedef enum logic {INC, DEC} dir_e;

  logic [10:0]        img_x_q, img_x_d, img_y_q, img_y_d;
  dir_e               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic               bounce_q, bounce_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               in_img_q, in_img_d, in_brd_q, in_brd_d;
  logic [ROM_LAT-1:0] img_pipe_q, img_pipe_d, brd_pipe_q, brd_pipe_d;
  logic [23:0]        pixel_data_q, pixel_data_d;
  logic [11:0]        rx, ry;
  logic               tick, refl_x, refl_y;

  // An axis whose footprint fills the screen (lim==0) never moves and never reflects.
  function automatic void axis_step(
    input  logic [10:0] pos,
    input  dir_e        dir,
    input  logic [10:0] lim,
    output logic [10:0] pos_n,
    output dir_e        dir_n,
    output logic        refl
  );
    pos_n = pos;
    dir_n = dir;
    refl  = 1'b0;
    if (lim != 11'd0) begin
      if (dir == INC) begin
        if (({1'b0, pos} + 12'(STEP)) >= {1'b0, lim}) begin
          pos_n = lim;
          dir_n = DEC;
          refl  = 1'b1;
        end else begin
          pos_n = pos + 11'(STEP);
        end
      end else if (pos <= 11'(STEP)) begin
        pos_n = '0;
        dir_n = INC;
        refl  = 1'b1;
      end else begin
        pos_n = pos - 11'(STEP);
      end
    end
  endfunction

  always_comb begin
    rx = {1'b0, pixel_xpos} - {1'b0, img_x_q};
    ry = {1'b0, pixel_ypos} - {1'b0, img_y_q};
    in_img_d = (pixel_xpos >= img_x_q) && (rx < 12'(SW)) &&
               (pixel_ypos >= img_y_q) && (ry < 12'(SH));
    in_brd_d = in_img_d && ((rx < 12'(BORDER_W)) || (rx >= 12'(SW - BORDER_W)) ||
                            (ry < 12'(BORDER_W)) || (ry >= 12'(SH - BORDER_W)));
    rom_addr_d = '0;
    if (in_img_d) begin
      rom_addr_d = ADDR_W'((({20'd0, ry} >> SCALE_LOG2) * IMG_W) + ({20'd0, rx} >> SCALE_LOG2));
    end

    // Flags ride alongside the ROM read so they meet rom_data on the same edge.
    img_pipe_d    = img_pipe_q;
    brd_pipe_d    = brd_pipe_q;
    img_pipe_d[0] = in_img_q;
    brd_pipe_d[0] = in_brd_q;
    for (int i = 1; i < ROM_LAT; i++) begin
      img_pipe_d[i] = img_pipe_q[i-1];
      brd_pipe_d[i] = brd_pipe_q[i-1];
    end

    pixel_data_d = BG_COLOR;
    if (brd_pipe_q[ROM_LAT-1]) begin
      pixel_data_d = BORDER_COLOR;
    end else if (img_pipe_q[ROM_LAT-1] && (rom_data ^ invert)) begin
      pixel_data_d = FG_COLOR;
    end
  end

  always_comb begin
    tick    = (pixel_xpos == 11'(H_DISP - 1)) && (pixel_ypos == 11'(V_DISP - 1));
    img_x_d = img_x_q;
    img_y_d = img_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    refl_x  = 1'b0;
    refl_y  = 1'b0;
    if (tick && move_en) begin
      axis_step(img_x_q, dir_x_q, 11'(MAX_X), img_x_d, dir_x_d, refl_x);
      axis_step(img_y_q, dir_y_q, 11'(MAX_Y), img_y_d, dir_y_d, refl_y);
    end
    bounce_d = refl_x | refl_y;
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      img_x_q      <= 11'(MAX_X / 2);
      img_y_q      <= 11'(MAX_Y / 2);
      dir_x_q      <= INC;
      dir_y_q      <= INC;
      bounce_q     <= 1'b0;
      rom_addr_q   <= '0;
      in_img_q     <= 1'b0;
      in_brd_q     <= 1'b0;
      img_pipe_q   <= '0;
      brd_pipe_q   <= '0;
      pixel_data_q <= '0;
    end else begin
      img_x_q      <= img_x_d;
      img_y_q      <= img_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      bounce_q     <= bounce_d;
      rom_addr_q   <= rom_addr_d;
      in_img_q     <= in_img_d;
      in_brd_q     <= in_brd_d;
      img_pipe_q   <= img_pipe_d;
      brd_pipe_q   <= brd_pipe_d;
      pixel_data_q <= pixel_data_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign pixel_data = pixel_data_q;
  assign img_x      = img_x_q;
  assign img_y      = img_y_q;
  assign bounce     = bounce_q;

endmodule

// File: tb/tb_video_sprite_display.sv
// tb/tb_video_sprite_display.sv - scoreboard bench for video_sprite_display over four parameter sets
module tb_video_sprite_display;
  logic clk, rst_n, rst_a_n;
  int   checks, errors;

  logic [10:0] xpos_a, ypos_a, img_x_a, img_y_a;
  logic        move_en_a, invert_a, rom_a_q, rom_mode_a, bounce_a;
  logic [15:0] rom_addr_a;
  logic [23:0] pixel_data_a;

  logic [10:0] xpos_s, ypos_s, img_x_s, img_y_s;
  logic        move_en_s, invert_s, rom_s1_q, rom_s2_q, bounce_s;
  logic [15:0] rom_addr_s;
  logic [23:0] pixel_data_s;

  logic [10:0] xpos_b, ypos_b, img_x_b, img_y_b;
  logic        move_en_b, invert_b, rom_b, bounce_b;
  logic [15:0] rom_addr_b;
  logic [23:0] pixel_data_b;

  logic [10:0] xpos_c, ypos_c, img_x_c, img_y_c;
  logic        move_en_c, invert_c, rom_c, bounce_c;
  logic [14:0] rom_addr_c;
  logic [23:0] pixel_data_c;

  always #5 clk = ~clk;

  always @(posedge clk) rom_a_q <= rom_mode_a ? (rom_addr_a[0] ^ rom_addr_a[8]) : 1'b1;
  always @(posedge clk) begin
    rom_s1_q <= rom_addr_s[0] ^ rom_addr_s[8];
    rom_s2_q <= rom_s1_q;
  end

  video_sprite_display dut_a (
    .pixel_clk(clk), .sys_rst_n(rst_a_n), .pixel_xpos(xpos_a), .pixel_ypos(ypos_a),
    .move_en(move_en_a), .invert(invert_a), .rom_data(rom_a_q), .rom_addr(rom_addr_a),
    .pixel_data(pixel_data_a), .img_x(img_x_a), .img_y(img_y_a), .bounce(bounce_a));

  video_sprite_display #(.SCALE_LOG2(1), .ROM_LAT(2)) dut_s (
    .pixel_clk(clk), .sys_rst_n(rst_n), .pixel_xpos(xpos_s), .pixel_ypos(ypos_s),
    .move_en(move_en_s), .invert(invert_s), .rom_data(rom_s2_q), .rom_addr(rom_addr_s),
    .pixel_data(pixel_data_s), .img_x(img_x_s), .img_y(img_y_s), .bounce(bounce_s));

  video_sprite_display #(.STEP(4)) dut_b (
    .pixel_clk(clk), .sys_rst_n(rst_n), .pixel_xpos(xpos_b), .pixel_ypos(ypos_b),
    .move_en(move_en_b), .invert(invert_b), .rom_data(rom_b), .rom_addr(rom_addr_b),
    .pixel_data(pixel_data_b), .img_x(img_x_b), .img_y(img_y_b), .bounce(bounce_b));

  video_sprite_display #(.H_DISP(256), .V_DISP(136), .IMG_W(256), .IMG_H(128),
                         .ADDR_W(15), .STEP(8)) dut_c (
    .pixel_clk(clk), .sys_rst_n(rst_n), .pixel_xpos(xpos_c), .pixel_ypos(ypos_c),
    .move_en(move_en_c), .invert(invert_c), .rom_data(rom_c), .rom_addr(rom_addr_c),
    .pixel_data(pixel_data_c), .img_x(img_x_c), .img_y(img_y_c), .bounce(bounce_c));

  function automatic logic [23:0] exp_pix(int x, int y, int ix, int iy, int sw, int sh,
                                          int sc, bit inv, bit chk);
    int rx, ry;
    bit d;
    rx = x - ix;
    ry = y - iy;
    if (rx < 0 || ry < 0 || rx >= sw || ry >= sh) return 24'h000000;
    if (rx < 2 || ry < 2 || rx >= sw - 2 || ry >= sh - 2) return 24'hFF0000;
    d = chk ? ((((rx >> sc) ^ (ry >> sc)) & 1) != 0) : 1'b1;
    return (d ^ inv) ? 24'hC030A0 : 24'h000000;
  endfunction

  function automatic void mstep(inout int p, inout bit dec, input int mx, input int st,
                                output bit r);
    r = 1'b0;
    if (mx == 0) return;
    if (!dec) begin
      if (p + st >= mx) begin p = mx; dec = 1'b1; r = 1'b1; end
      else p = p + st;
    end else begin
      if (p <= st) begin p = 0; dec = 1'b0; r = 1'b1; end
      else p = p - st;
    end
  endfunction

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (pixel_data_a !== 24'h0 || rom_addr_a !== 16'h0 || bounce_a !== 1'b0) begin
      errors++; $display("FAIL rst_a_out got pix=%h addr=%h b=%b exp 0/0/0", pixel_data_a, rom_addr_a, bounce_a); end
    checks++; if (img_x_a !== 11'd272 || img_y_a !== 11'd172) begin
      errors++; $display("FAIL rst_a_pos got %0d,%0d exp 272,172", img_x_a, img_y_a); end
    checks++; if (img_x_s !== 11'd144 || img_y_s !== 11'd44 || pixel_data_s !== 24'h0) begin
      errors++; $display("FAIL rst_s got %0d,%0d pix=%h exp 144,44,0", img_x_s, img_y_s, pixel_data_s); end
    checks++; if (img_x_b !== 11'd272 || img_y_b !== 11'd172 || bounce_b !== 1'b0) begin
      errors++; $display("FAIL rst_b got %0d,%0d b=%b exp 272,172,0", img_x_b, img_y_b, bounce_b); end
    checks++; if (img_x_c !== 11'd0 || img_y_c !== 11'd4 || rom_addr_c !== 15'h0) begin
      errors++; $display("FAIL rst_c got %0d,%0d addr=%h exp 0,4,0", img_x_c, img_y_c, rom_addr_c); end
    rst_n = 1'b1;
    rst_a_n = 1'b1;
  endtask

  task automatic test_pixel_select;
    int xs[$] = '{2047, 271, 272, 273, 274, 274, 275, 527, 528, 400, 400, 100, 272};
    int ys[$] = '{2047, 172, 172, 172, 174, 172, 175, 173, 173, 427, 428, 100, 172};
    logic [23:0] q[$];
    logic [23:0] e;
    rom_mode_a = 1'b0;
    invert_a = 1'b0;
    for (int i = 0; i < xs.size() + 3; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        e = q.pop_front();
        checks++; if (pixel_data_a !== e) begin
          errors++; $display("FAIL pix_sel[%0d] got %h exp %h", i - 3, pixel_data_a, e); end
      end
      if (i < xs.size()) begin
        xpos_a = 11'(xs[i]); ypos_a = 11'(ys[i]);
        q.push_back(exp_pix(xs[i], ys[i], 272, 172, 256, 256, 0, 1'b0, 1'b0));
      end else begin
        xpos_a = 11'd2047; ypos_a = 11'd2047;
      end
    end
  endtask

  task automatic test_address_scale;
    int rxs[$] = '{5, 6, 7, 8, 9, 0, 1, 511, 300, -1, 512, 10, 3, 4};
    int rys[$] = '{9, 9, 9, 9, 9, 0, 5, 20, 511, 10, 10, 10, 200, 200};
    int qa[$];
    logic [23:0] qp[$];
    int ea;
    logic [23:0] ep;
    for (int i = 0; i < rxs.size() + 4; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= rxs.size()) begin
        ea = qa.pop_front();
        checks++; if (rom_addr_s !== 16'(ea)) begin
          errors++; $display("FAIL addr_s[%0d] got %h exp %h", i - 1, rom_addr_s, 16'(ea)); end
      end
      if (i >= 4) begin
        ep = qp.pop_front();
        checks++; if (pixel_data_s !== ep) begin
          errors++; $display("FAIL pix_s[%0d] got %h exp %h", i - 4, pixel_data_s, ep); end
      end
      if (i < rxs.size()) begin
        xpos_s = 11'(144 + rxs[i]); ypos_s = 11'(44 + rys[i]);
        if (rxs[i] >= 0 && rxs[i] < 512 && rys[i] >= 0 && rys[i] < 512)
          qa.push_back(((rys[i] >> 1) << 8) | (rxs[i] >> 1));
        else
          qa.push_back(0);
        qp.push_back(exp_pix(144 + rxs[i], 44 + rys[i], 144, 44, 512, 512, 1, 1'b0, 1'b1));
      end else begin
        xpos_s = 11'd2047; ypos_s = 11'd2047;
      end
    end
  endtask

  task automatic test_invert;
    int xs[$] = '{272, 273, 274, 275, 276, 276, 271, 527, 300, 301, 400};
    int ys[$] = '{172, 173, 174, 174, 175, 176, 180, 300, 300, 300, 427};
    logic [23:0] q[$];
    logic [23:0] e;
    rom_mode_a = 1'b1;
    invert_a = 1'b1;
    for (int i = 0; i < xs.size() + 3; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        e = q.pop_front();
        checks++; if (pixel_data_a !== e) begin
          errors++; $display("FAIL invert[%0d] got %h exp %h", i - 3, pixel_data_a, e); end
      end
      if (i < xs.size()) begin
        xpos_a = 11'(xs[i]); ypos_a = 11'(ys[i]);
        q.push_back(exp_pix(xs[i], ys[i], 272, 172, 256, 256, 0, 1'b1, 1'b1));
      end else begin
        xpos_a = 11'd2047; ypos_a = 11'd2047;
      end
    end
    invert_a = 1'b0;
    rom_mode_a = 1'b0;
  endtask

  task automatic test_bounce;
    int px = 272, py = 172, nexp = 0, ndut = 0, idx = -1, zidx = -1;
    bit dx = 1'b0, dy = 1'b0, rx, ry;
    int q[$];
    int xs_seen[$];
    int e;
    @(negedge clk);
    xpos_b = 11'd799; ypos_b = 11'd599; move_en_b = 1'b0;
    @(negedge clk);
    checks++; if (img_x_b !== 11'd272 || img_y_b !== 11'd172 || bounce_b !== 1'b0) begin
      errors++; $display("FAIL hold_b got %0d,%0d b=%b exp 272,172,0", img_x_b, img_y_b, bounce_b); end
    xpos_b = 11'd0; ypos_b = 11'd0; move_en_b = 1'b1;
    for (int t = 0; t < 220; t++) begin
      @(negedge clk);
      checks++; if (bounce_b !== 1'b0) begin
        errors++; $display("FAIL bounce_width[%0d] got %b exp 0", t, bounce_b); end
      xpos_b = 11'd799; ypos_b = 11'd599;
      mstep(px, dx, 544, 4, rx);
      mstep(py, dy, 344, 4, ry);
      if (rx || ry) nexp++;
      q.push_back((px << 12) | (py << 1) | int'(rx | ry));
      @(negedge clk);
      e = q.pop_front();
      checks++; if (img_x_b !== 11'(e >> 12) || img_y_b !== 11'((e >> 1) & 11'h7FF) ||
                    bounce_b !== 1'(e & 1)) begin
        errors++; $display("FAIL move_b[%0d] got %0d,%0d,%b exp %0d,%0d,%0d", t, img_x_b, img_y_b,
                           bounce_b, e >> 12, (e >> 1) & 11'h7FF, e & 1); end
      if (bounce_b === 1'b1) ndut++;
      xs_seen.push_back(int'(img_x_b));
      xpos_b = 11'd0; ypos_b = 11'd0;
    end
    for (int i = 0; i < xs_seen.size(); i++) begin
      if (xs_seen[i] == 544 && idx < 0) idx = i;
      if (xs_seen[i] == 0 && zidx < 0) zidx = i;
    end
    checks++; if (idx < 0 || idx + 2 >= xs_seen.size() || xs_seen[idx+1] != 540 || xs_seen[idx+2] != 536) begin
      errors++; $display("FAIL x_reflect_max got idx=%0d exp 544,540,536 sequence", idx); end
    checks++; if (zidx < 0 || zidx + 1 >= xs_seen.size() || xs_seen[zidx+1] != 4) begin
      errors++; $display("FAIL x_reflect_zero got idx=%0d exp 0 then 4", zidx); end
    checks++; if (ndut != nexp) begin
      errors++; $display("FAIL bounce_count got %0d exp %0d", ndut, nexp); end
    move_en_b = 1'b0;
    @(negedge clk);
    xpos_b = 11'd799; ypos_b = 11'd599;
    @(negedge clk);
    checks++; if (img_x_b !== 11'(px) || img_y_b !== 11'(py) || bounce_b !== 1'b0) begin
      errors++; $display("FAIL hold_b_end got %0d,%0d exp %0d,%0d", img_x_b, img_y_b, px, py); end
    xpos_b = 11'd2047; ypos_b = 11'd2047;
  endtask

  task automatic test_corner;
    int px = 0, py = 4;
    bit dx = 1'b0, dy = 1'b0, rx, ry;
    move_en_c = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      xpos_c = 11'd255; ypos_c = 11'd135;
      mstep(px, dx, 0, 8, rx);
      mstep(py, dy, 8, 8, ry);
      @(negedge clk);
      checks++; if (img_x_c !== 11'(px) || img_y_c !== 11'(py) || bounce_c !== 1'(rx | ry)) begin
        errors++; $display("FAIL corner[%0d] got %0d,%0d,%b exp %0d,%0d,%0d", t, img_x_c, img_y_c,
                           bounce_c, px, py, rx | ry); end
      xpos_c = 11'd0; ypos_c = 11'd0;
      @(negedge clk);
      checks++; if (bounce_c !== 1'b0) begin
        errors++; $display("FAIL corner_pulse[%0d] got %b exp 0", t, bounce_c); end
    end
    move_en_c = 1'b0;
  endtask

  task automatic test_reset_mid;
    rom_mode_a = 1'b0;
    invert_a = 1'b0;
    @(negedge clk);
    xpos_a = 11'd300; ypos_a = 11'd300;
    repeat (4) @(negedge clk);
    checks++; if (pixel_data_a !== 24'hC030A0) begin
      errors++; $display("FAIL pre_rst_fg got %h exp c030a0", pixel_data_a); end
    rst_a_n = 1'b0;
    #1;
    checks++; if (pixel_data_a !== 24'h0 || rom_addr_a !== 16'h0 || bounce_a !== 1'b0) begin
      errors++; $display("FAIL rst_mid_out got pix=%h addr=%h exp 0/0", pixel_data_a, rom_addr_a); end
    checks++; if (img_x_a !== 11'd272 || img_y_a !== 11'd172) begin
      errors++; $display("FAIL rst_mid_pos got %0d,%0d exp 272,172", img_x_a, img_y_a); end
    repeat (3) @(negedge clk);
    rst_a_n = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checks++; if (pixel_data_a !== 24'h0) begin
        errors++; $display("FAIL post_rst_bg[%0d] got %h exp 000000", i, pixel_data_a); end
    end
    @(negedge clk);
    checks++; if (pixel_data_a !== 24'hC030A0) begin
      errors++; $display("FAIL post_rst_fg got %h exp c030a0", pixel_data_a); end
    xpos_a = 11'd2047; ypos_a = 11'd2047;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; rst_a_n = 1'b0;
    checks = 0; errors = 0;
    xpos_a = 11'd2047; ypos_a = 11'd2047; move_en_a = 1'b0; invert_a = 1'b0; rom_mode_a = 1'b0;
    xpos_s = 11'd2047; ypos_s = 11'd2047; move_en_s = 1'b0; invert_s = 1'b0;
    xpos_b = 11'd2047; ypos_b = 11'd2047; move_en_b = 1'b0; invert_b = 1'b0; rom_b = 1'b0;
    xpos_c = 11'd2047; ypos_c = 11'd2047; move_en_c = 1'b0; invert_c = 1'b0; rom_c = 1'b0;
    test_reset();
    test_pixel_select();
    test_address_scale();
    test_invert();
    test_bounce();
    test_corner();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
